// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the RegisterFile write port: round-robin between ALU and load unit,
// registered write toward the RegisterFile, and a per-register busy scoreboard.
module regfile_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_wd,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_wd,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wd,
    output logic [NREG-1:0] busy,
    output logic [CNTW-1:0] conflict_cnt
);

    typedef enum logic {
        PRI_ALU,
        PRI_MEM
    } pri_t;

    pri_t            pri_q;
    pri_t            pri_d;
    logic            alu_gnt;
    logic            mem_gnt;
    logic [NREG-1:0] busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q <= PRI_ALU;
        end else begin
            pri_q <= pri_d;
        end
    end

    // Grants depend only on valids and the pointer, so ready never rises without valid.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        pri_d   = pri_q;
        if (alu_valid && (!mem_valid || pri_q == PRI_ALU)) begin
            alu_gnt = 1'b1;
            pri_d   = PRI_MEM;
        end else if (mem_valid) begin
            mem_gnt = 1'b1;
            pri_d   = PRI_ALU;
        end
    end

    assign alu_ready = alu_gnt;
    assign mem_ready = mem_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_rd <= '0;
            rf_wd <= '0;
        end else if (alu_gnt) begin
            rf_we <= (alu_rd != '0);
            rf_rd <= alu_rd;
            rf_wd <= alu_wd;
        end else if (mem_gnt) begin
            rf_we <= (mem_rd != '0);
            rf_rd <= mem_rd;
            rf_wd <= mem_wd;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Clear on the commit edge, then set, so a newer producer keeps the register busy.
    always_comb begin
        busy_d = busy;
        if (rf_we) begin
            busy_d[rf_rd] = 1'b0;
        end
        if (iss_valid) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (alu_valid && mem_valid && conflict_cnt != '1) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writeback arbiter and scoreboard for the 32x64 RegisterFile single write port (we/rd/wd). It shares the write port between two writeback sources, the ALU and the load/memory unit, using valid/ready handshakes and round-robin priority. It registers the winning write into the RegisterFile port. It also keeps a per-register busy scoreboard: the issue stage sets a bit, and the committed writeback clears it.

Parameters:
XLEN, 64, data width of write data and RegisterFile entries
NREG, 32, number of architectural registers
AW, 5, register index width, log2(NREG)
CNTW, 16, width of the conflict counter

Ports:
clk  input  1  rising-edge clock shared with RegisterFile
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted this cycle
alu_rd  input  AW  ALU destination register
alu_wd  input  XLEN  ALU result
mem_valid  input  1  load writeback request
mem_ready  output  1  load request accepted this cycle
mem_rd  input  AW  load destination register
mem_wd  input  XLEN  load data
iss_valid  input  1  issue stage allocates a destination
iss_rd  input  AW  destination being allocated
rf_we  output  1  to RegisterFile we, registered
rf_rd  output  AW  to RegisterFile rd, registered
rf_wd  output  XLEN  to RegisterFile wd, registered
busy  output  NREG  scoreboard; bit i=1 means xi has a write pending
conflict_cnt  output  CNTW  saturating count of cycles with both sources valid

Behaviour:
- Reset (rst_n=0, async): rf_we=0, rf_rd=0, rf_wd=0, busy=0, conflict_cnt=0, priority pointer=ALU. A captured write that is not yet committed is discarded.
- Handshake: transfer occurs when valid&ready at a rising edge. Sources hold valid, rd and wd stable until ready. ready is combinational from the valid inputs and the pointer. ready is never asserted without the matching valid.
- Arbitration, at most one grant per cycle:
  - Only one source valid: that source is granted.
  - Both valid: the source named by the pointer is granted.
  - After any grant, the pointer moves to the other source. With no grant, the pointer holds.
- Write latency:
  - A grant at edge E loads rf_rd/rf_wd from the winner. rf_we=1 for the cycle after E if rd!=0.
  - RegisterFile commits at edge E+1.
  - With no grant at E, rf_we=0 after E; rf_rd/rf_wd hold their values.
- x0: a request with rd=0 is granted normally and moves the pointer, but rf_we stays 0.
- Throughput: one write per cycle with back-to-back grants. rf_we can stay high every cycle.
- Scoreboard:
  - iss_valid with iss_rd!=0 sets busy[iss_rd] at the edge.
  - A clear happens at the edge where rf_we=1 for rf_rd, i.e. the commit edge, so busy never drops before the data is in RegisterFile.
  - Set and clear of the same register at one edge: set wins (a newer producer exists).
  - busy[0] is constant 0.
  - A set on an already-busy register leaves it busy; no counting.
- conflict_cnt increments at each edge where alu_valid&mem_valid. It saturates at all-ones.
- No combinational path from the alu/mem inputs to the rf_* outputs or to busy.

Test Plan:
1. Reset, then alu_valid with alu_rd=1, alu_wd=64'hDEADBEEFCAFEBABE -> alu_ready=1 in the same cycle; next cycle rf_we=1, rf_rd=1, rf_wd=DEADBEEFCAFEBABE; RegisterFile x1 reads DEADBEEFCAFEBABE one edge later.
2. Both valid for 4 cycles (ALU rd=2/3, mem rd=4/5, each source re-presenting after its grant) -> grant order ALU, MEM, ALU, MEM; rf_rd sequence 2,4,3,5; conflict_cnt=4.
3. mem_valid with mem_rd=0, mem_wd=64'hFFFFFFFFFFFFFFFF -> mem_ready=1, rf_we stays 0, x0 reads 0, pointer moves to ALU.
4. iss_valid with iss_rd=5 -> busy[5]=1. ALU write to x5 with 64'h123456789ABCDEF0 -> busy[5] clears at the commit edge, the same edge x5 updates. iss_rd=5 and a commit to x5 at the same edge -> busy[5] stays 1.
5. Grant a write, then assert rst_n=0 before the commit edge -> rf_we drops immediately, RegisterFile is not written, busy=0, next grant goes to ALU.
6. Hold both valid for 2^16+3 cycles -> conflict_cnt saturates at 16'hFFFF.
